// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder.
// SYNC + LSB-first serialiser, bit stuffing, NRZI and EOP.
module usb_tx_encoder #(
  parameter logic [7:0] SYNC_PATTERN = 8'h80,
  parameter int         STUFF_LIMIT  = 6,
  parameter int         EOP_SE0_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bit_strobe,
  input  logic [7:0] tx_data,
  input  logic       tx_last,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       d_plus,
  output logic       d_minus,
  output logic       tx_active,
  output logic       tx_done,
  output logic       tx_error
);

  localparam int SE0_W =
    (EOP_SE0_BITS > 1) ? $clog2(EOP_SE0_BITS) : 1;
  localparam logic [SE0_W-1:0] SE0_LAST =
    SE0_W'(EOP_SE0_BITS - 1);
  localparam logic [2:0] ONES_MAX = 3'(STUFF_LIMIT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_DATA,
    S_STUFF,
    S_EOP_SE0,
    S_EOP_J
  } state_t;

  state_t           state;
  state_t           ret;
  logic [2:0]       bit_cnt;
  logic [2:0]       ones_cnt;
  logic [SE0_W-1:0] se0_cnt;
  logic [7:0]       shreg;
  logic             cur_last;
  logic             nrzi;

  logic [7:0]       hold_data;
  logic             hold_last;
  logic             hold_full;

  state_t           pos;
  logic [2:0]       nxt_idx;
  logic             stuff_due;
  logic             tx_en;
  logic             tx_bit;
  logic             tx_base;
  logic             tx_nrzi;
  logic             load;

  assign tx_ready = !hold_full;

  // Stuff bits resume at the serial position they interrupted.
  assign pos     = (state == S_STUFF) ? ret : state;
  assign nxt_idx = bit_cnt + 3'd1;
  assign stuff_due =
    ((state == S_SYNC) || (state == S_DATA)) &&
    (ones_cnt == ONES_MAX);
  assign tx_nrzi = tx_bit ? tx_base : ~tx_base;

  // Pick the next serial bit and whether the held byte is consumed.
  always_comb begin
    tx_en   = 1'b0;
    tx_bit  = 1'b0;
    tx_base = nrzi;
    load    = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (hold_full) begin
          tx_en   = 1'b1;
          tx_bit  = SYNC_PATTERN[0];
          tx_base = 1'b1;
        end
      end
      S_SYNC, S_DATA, S_STUFF: begin
        if (stuff_due) begin
          tx_en  = 1'b1;
          tx_bit = 1'b0;
        end else if (bit_cnt != 3'd7) begin
          tx_en  = 1'b1;
          tx_bit = (pos == S_SYNC) ?
                   SYNC_PATTERN[nxt_idx] :
                   shreg[nxt_idx];
        end else if ((pos == S_SYNC) ||
                     (!cur_last && hold_full)) begin
          tx_en  = 1'b1;
          tx_bit = hold_data[0];
          load   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Handshake, framing FSM and registered line drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      ret       <= S_SYNC;
      bit_cnt   <= 3'd0;
      ones_cnt  <= 3'd0;
      se0_cnt   <= '0;
      shreg     <= 8'h00;
      cur_last  <= 1'b0;
      nrzi      <= 1'b1;
      hold_data <= 8'h00;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      d_plus    <= 1'b1;
      d_minus   <= 1'b0;
      tx_active <= 1'b0;
      tx_done   <= 1'b0;
      tx_error  <= 1'b0;
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      if (bit_strobe && load) begin
        shreg     <= hold_data;
        cur_last  <= hold_last;
        hold_full <= 1'b0;
      end
      if (tx_valid && tx_ready) begin
        hold_data <= tx_data;
        hold_last <= tx_last;
        hold_full <= 1'b1;
      end
      if (bit_strobe) begin
        if (tx_en) begin
          nrzi     <= tx_nrzi;
          d_plus   <= tx_nrzi;
          d_minus  <= ~tx_nrzi;
          ones_cnt <= tx_bit ? ones_cnt + 3'd1 : 3'd0;
        end
        unique case (state)
          S_IDLE: begin
            if (hold_full) begin
              state     <= S_SYNC;
              bit_cnt   <= 3'd0;
              tx_active <= 1'b1;
            end
          end
          S_SYNC, S_DATA, S_STUFF: begin
            if (stuff_due) begin
              ret   <= state;
              state <= S_STUFF;
            end else if (bit_cnt != 3'd7) begin
              state   <= pos;
              bit_cnt <= nxt_idx;
            end else if (load) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end else begin
              state    <= S_EOP_SE0;
              se0_cnt  <= '0;
              ones_cnt <= 3'd0;
              d_plus   <= 1'b0;
              d_minus  <= 1'b0;
              tx_error <= !cur_last;
            end
          end
          S_EOP_SE0: begin
            if (se0_cnt == SE0_LAST) begin
              state   <= S_EOP_J;
              d_plus  <= 1'b1;
              d_minus <= 1'b0;
            end else begin
              se0_cnt <= se0_cnt + 1'b1;
            end
          end
          S_EOP_J: begin
            state     <= S_IDLE;
            tx_done   <= 1'b1;
            tx_active <= 1'b0;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder.
// Reference NRZI/stuffing model feeds a line-symbol scoreboard.
module tb_usb_tx_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       bit_strobe = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       d_plus;
  logic       d_minus;
  logic       tx_active;
  logic       tx_done;
  logic       tx_error;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_q[$];
  int         pops = 0;
  int         act_cnt = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] mb[4];
  bit         strobe_en = 1'b1;
  logic [1:0] scnt = 2'd0;

  usb_tx_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .bit_strobe(bit_strobe),
    .tx_data   (tx_data),
    .tx_last   (tx_last),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .d_plus    (d_plus),
    .d_minus   (d_minus),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (strobe_en) begin
      bit_strobe = (scnt == 2'd3);
      scnt = scnt + 2'd1;
    end else begin
      bit_strobe = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  // Compare one line symbol per bit time while a packet is in flight.
  always @(posedge clk) begin
    logic pre_act;
    logic [2:0] e;
    if (bit_strobe && !rst) begin
      pre_act = tx_active;
      #1;
      if (tx_active) act_cnt++;
      if (pre_act || tx_active) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("line", 32'({tx_active, d_plus, d_minus}),
                32'(e));
          pops++;
        end
      end
    end
  end

  task automatic model(input int n);
    logic       lvl;
    int         ones;
    logic [7:0] b;
    logic       d;
    lvl  = 1'b1;
    ones = 0;
    for (int i = 0; i < 8 + 8 * n; i++) begin
      b = (i < 8) ? 8'h80 : mb[(i - 8) / 8];
      d = b[i % 8];
      if (!d) lvl = ~lvl;
      exp_q.push_back({1'b1, lvl, ~lvl});
      ones = d ? ones + 1 : 0;
      if (ones == 6) begin
        lvl = ~lvl;
        exp_q.push_back({1'b1, lvl, ~lvl});
        ones = 0;
      end
    end
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b100);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b010);
  endtask

  task automatic put_byte(input logic [7:0] d,
                          input logic l);
    int n;
    n = 0;
    @(negedge clk);
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) check("accept_tmo", 32'd0, 32'd1);
    @(posedge clk);
    #1 tx_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() > 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain", 32'(exp_q.size()), 32'd0);
    repeat (3) @(negedge clk);
    exp_q.delete();
  endtask

  task automatic run_pkt(input string tag, input int n,
                         input int bits, input int errs);
    int d0;
    int e0;
    d0 = done_cnt;
    e0 = err_cnt;
    act_cnt = 0;
    model(n);
    for (int i = 0; i < n; i++)
      put_byte(mb[i], (errs == 0) && (i == n - 1));
    drain();
    check({tag, "_done"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_err"}, 32'(err_cnt - e0), 32'(errs));
    check({tag, "_bits"}, 32'(act_cnt), 32'(bits));
    check({tag, "_idle"},
          32'({tx_active, tx_ready, d_plus, d_minus}),
          32'(4'b0110));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int d0;
    int n;
    repeat (3) @(posedge clk);
    #1;
    check("rst_line", 32'({d_plus, d_minus}), 32'(2'b10));
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_active", 32'(tx_active), 32'd0);
    check("rst_pulses", 32'({tx_done, tx_error}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);

    mb[0] = 8'h00;
    run_pkt("b00", 1, 19, 0);

    mb[0] = 8'hFF;
    run_pkt("bff", 1, 20, 0);

    mb[0] = 8'h3F;
    mb[1] = 8'h01;
    run_pkt("b3f01", 2, 28, 0);

    mb[0] = 8'hA5;
    run_pkt("under", 1, 19, 1);

    // Reset while DATA bit 3 is on the line.
    mb[0] = 8'h00;
    d0 = done_cnt;
    pops = 0;
    model(1);
    put_byte(8'h00, 1'b1);
    n = 0;
    while (pops < 12 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rst_reach", 32'(pops), 32'd12);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst",
          32'({tx_active, tx_ready, d_plus, d_minus}),
          32'(4'b0110));
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    repeat (40) @(negedge clk);
    check("mid_rst_noeop", 32'(done_cnt - d0), 32'd0);
    check("mid_rst_line",
          32'({tx_active, d_plus, d_minus}), 32'(3'b010));

    // Byte offered while the bit timer is stalled.
    @(posedge clk);
    #2 strobe_en = 1'b0;
    mb[0] = 8'h00;
    act_cnt = 0;
    d0 = done_cnt;
    model(1);
    put_byte(8'h00, 1'b1);
    repeat (20) @(negedge clk);
    check("stall_acc", 32'(tx_ready), 32'd0);
    check("stall_line",
          32'({tx_active, d_plus, d_minus}), 32'(3'b010));
    @(posedge clk);
    #2 strobe_en = 1'b1;
    drain();
    check("stall_done", 32'(done_cnt - d0), 32'd1);
    check("stall_bits", 32'(act_cnt), 32'd19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
